// File: rtl/mvm_pkg.sv
// Shared mvm defaults and streamer state encoding.
package mvm_pkg;

   localparam int unsigned MVM_MATRIX_ROWS = 6;
   localparam int unsigned MVM_SHARED_DIM  = 3;
   localparam int unsigned MVM_WIDTH       = 8;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   // Index width that stays legal for a single-element vector.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mvm_sat_narrow.sv
// Signed saturate-and-narrow of one element from IN_W to OUT_W bits.
module mvm_sat_narrow
   import mvm_pkg::*;
#(
   parameter int unsigned IN_W  = MVM_WIDTH,
   parameter int unsigned OUT_W = MVM_WIDTH
) (
   input  logic [IN_W-1:0]  elem,
   output logic [OUT_W-1:0] sat_c
);

   localparam int unsigned HI_W = IN_W - OUT_W + 1;
   localparam logic [OUT_W-1:0] MIN_V = OUT_W'(1) << (OUT_W - 1);

   // The element fits when every bit from the output sign bit upward matches.
   logic [HI_W-1:0] hi;
   assign hi = elem[IN_W-1:OUT_W-1];

   always_comb begin
      sat_c = elem[OUT_W-1:0];
      if ((hi != '0) && (hi != '1)) begin
         sat_c = elem[IN_W-1] ? MIN_V : ~MIN_V;
      end
   end

endmodule

// File: rtl/mvm_result_streamer.sv
// Snapshots the mvm result vector on capture and streams saturated elements over valid/ready.
module mvm_result_streamer
   import mvm_pkg::*;
#(
   parameter int unsigned MATRIX_ROWS = MVM_MATRIX_ROWS,
   parameter int unsigned SHARED_DIM  = MVM_SHARED_DIM,
   parameter int unsigned WIDTH       = MVM_WIDTH,
   parameter int unsigned OUT_WIDTH   = MVM_WIDTH,
   localparam int unsigned NUM_ELEMS  = MATRIX_ROWS * SHARED_DIM,
   localparam int unsigned IDX_W      = idx_width(NUM_ELEMS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       capture,
   input  logic [NUM_ELEMS*WIDTH-1:0] result_vector,
   output logic                       busy,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [OUT_WIDTH-1:0]       m_data,
   output logic [IDX_W-1:0]           m_index,
   output logic                       m_last,
   output logic                       overrun
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     snap_q [NUM_ELEMS];
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [OUT_WIDTH-1:0] data_q;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic                 overrun_q, overrun_d;
   logic                 load;
   logic                 upd;
   logic                 xfer;
   logic [WIDTH-1:0]     sel_elem;
   logic [OUT_WIDTH-1:0] sat_c;

   assign xfer = valid_q && m_ready;

   // Next state; a load fetches element 0 straight from the input bus since the snapshot lands on the same edge.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      last_d    = last_q;
      overrun_d = overrun_q;
      load      = 1'b0;
      upd       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (capture) begin
               state_d = ST_STREAM;
               load    = 1'b1;
            end
         end
         ST_STREAM: begin
            if (xfer && last_q) begin
               if (capture) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  idx_d   = '0;
               end
            end else begin
               if (xfer) begin
                  idx_d = idx_q + IDX_W'(1);
                  upd   = 1'b1;
               end
               if (capture) begin
                  overrun_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         idx_d   = '0;
         valid_d = 1'b1;
         upd     = 1'b1;
      end
      if (upd) begin
         last_d = (idx_d == IDX_W'(NUM_ELEMS - 1));
      end
      sel_elem = load ? result_vector[WIDTH-1:0] : snap_q[idx_d];
   end

   mvm_sat_narrow #(
      .IN_W  (WIDTH),
      .OUT_W (OUT_WIDTH)
   ) u_sat (
      .elem  (sel_elem),
      .sat_c (sat_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < NUM_ELEMS; i++) begin
            snap_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         overrun_q <= overrun_d;
         if (upd) begin
            data_q <= sat_c;
         end
         if (load) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
               snap_q[i] <= result_vector[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign busy    = valid_q;
   assign m_valid = valid_q;
   assign m_data  = data_q;
   assign m_index = idx_q;
   assign m_last  = last_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_mvm_result_streamer.sv
// Directed bench for mvm_result_streamer: pass-through instance plus a 4-bit saturating instance.
module tb_mvm_result_streamer;

   localparam int unsigned N = 18;
   localparam int unsigned W = 8;

   logic           clk     = 1'b0;
   logic           reset   = 1'b0;
   logic           capture = 1'b0;
   logic           m_ready = 1'b0;
   logic [N*W-1:0] rv      = '0;

   logic       busy, m_valid, m_last, overrun;
   logic [7:0] m_data;
   logic [4:0] m_index;
   logic       busy4, m_valid4, m_last4, overrun4;
   logic [3:0] m_data4;
   logic [4:0] m_index4;

   int vectors     = 0;
   int miscompares = 0;

   int sat_in  [7] = '{7, 8, -8, -9, 127, -128, -1};
   int sat_exp [7] = '{7, 7, -8, -8, 7, -8, -1};

   always #5 clk = ~clk;

   mvm_result_streamer #(.OUT_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .capture(capture), .result_vector(rv),
      .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_index(m_index), .m_last(m_last), .overrun(overrun)
   );

   mvm_result_streamer #(.OUT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .capture(capture), .result_vector(rv),
      .busy(busy4), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
      .m_index(m_index4), .m_last(m_last4), .overrun(overrun4)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int base, input int step);
      for (int i = 0; i < N; i++) rv[i*W +: W] = W'(base + step * i);
   endtask

   task automatic drain();
      for (int c = 0; c < 40 && m_valid; c++) tick();
      chk("drain_idle", int'(m_valid), 0);
   endtask

   initial begin
      int xf;

      // Reset state
      #1 reset = 1'b1;
      tick();
      tick();
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_data", int'(m_data), 0);
      chk("rst_index", int'(m_index), 0);
      chk("rst_last", int'(m_last), 0);
      chk("rst_overrun", int'(overrun), 0);
      reset = 1'b0;
      tick();

      // Full stream with m_ready held high
      set_vec(1, 1);
      capture = 1'b1;
      m_ready = 1'b1;
      tick();
      capture = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk("str_valid", int'(m_valid), 1);
         chk("str_busy", int'(busy), 1);
         chk("str_index", int'(m_index), k);
         chk("str_data", int'($signed(m_data)), k + 1);
         chk("str_last", int'(m_last), (k == N - 1) ? 1 : 0);
         tick();
      end
      chk("str_end_valid", int'(m_valid), 0);
      chk("str_end_busy", int'(busy), 0);
      chk("str_end_last", int'(m_last), 0);
      chk("str_end_data", int'($signed(m_data)), 18);

      // Backpressure with ready pattern 1,0,0,1
      set_vec(3, 2);
      capture = 1'b1;
      m_ready = 1'b0;
      tick();
      capture = 1'b0;
      xf = 0;
      for (int c = 0; c < 100 && xf < N; c++) begin
         m_ready = ((c % 4) == 0) || ((c % 4) == 3);
         chk("bp_valid", int'(m_valid), 1);
         chk("bp_index", int'(m_index), xf);
         chk("bp_data", int'($signed(m_data)), 2 * xf + 3);
         chk("bp_last", int'(m_last), (xf == N - 1) ? 1 : 0);
         if (m_valid && m_ready) xf++;
         tick();
      end
      chk("bp_count", xf, N);
      chk("bp_idle", int'(m_valid), 0);

      // Saturation to 4 bits, pass-through at 8 bits
      set_vec(0, 0);
      for (int i = 0; i < 7; i++) rv[i*W +: W] = W'(sat_in[i]);
      capture = 1'b1;
      m_ready = 1'b1;
      tick();
      capture = 1'b0;
      for (int k = 0; k < 7; k++) begin
         chk("sat4_data", int'($signed(m_data4)), sat_exp[k]);
         chk("sat4_index", int'(m_index4), k);
         chk("pass8_data", int'($signed(m_data)), sat_in[k]);
         tick();
      end
      drain();
      chk("sat_overrun", int'(overrun), 0);

      // Ignored capture mid-stream, then back-to-back capture on the last beat
      set_vec(10, 1);
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("ovr_pre_index", int'(m_index), 5);
      set_vec(100, 1);
      capture = 1'b1;
      tick();
      capture = 1'b0;
      chk("ovr_flag", int'(overrun), 1);
      chk("ovr_index", int'(m_index), 6);
      chk("ovr_data", int'($signed(m_data)), 16);
      for (int k = 6; k < 17; k++) tick();
      chk("b2b_old_index", int'(m_index), 17);
      chk("b2b_old_last", int'(m_last), 1);
      chk("b2b_old_data", int'($signed(m_data)), 27);
      set_vec(50, 1);
      capture = 1'b1;
      tick();
      capture = 1'b0;
      chk("b2b_valid", int'(m_valid), 1);
      chk("b2b_busy", int'(busy), 1);
      chk("b2b_index", int'(m_index), 0);
      chk("b2b_data", int'($signed(m_data)), 50);
      chk("b2b_last", int'(m_last), 0);
      chk("b2b_overrun", int'(overrun), 1);
      tick();
      chk("b2b_index1", int'(m_index), 1);
      chk("b2b_data1", int'($signed(m_data)), 51);
      drain();
      chk("ovr_sticky", int'(overrun), 1);

      // Asynchronous reset mid-stream, then restart
      set_vec(1, 1);
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      chk("mid_index", int'(m_index), 9);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", int'(m_valid), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_index", int'(m_index), 0);
      chk("arst_data", int'(m_data), 0);
      chk("arst_last", int'(m_last), 0);
      chk("arst_overrun", int'(overrun), 0);
      tick();
      reset = 1'b0;
      set_vec(30, -1);
      capture = 1'b1;
      tick();
      capture = 1'b0;
      chk("rs_valid", int'(m_valid), 1);
      chk("rs_index", int'(m_index), 0);
      chk("rs_data", int'($signed(m_data)), 30);
      chk("rs_overrun", int'(overrun), 0);
      tick();
      chk("rs_index1", int'(m_index), 1);
      chk("rs_data1", int'($signed(m_data)), 29);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
